short_solver: RTL and testbench
===============================

# short_solver

Fixed-size Smith-Waterman local aligner for two DNA sequences of compile-time lengths. It fills the score and direction matrices one cell per clock and tracks the maximum-scoring cell. It then traces back from that cell to produce the alignment path as a list of directions, and asserts `finished`. The block is a standalone compute core: sequences are applied as parallel ports and all results are exposed as register arrays for downstream or debug logic.

## Interface
Types come from `datatypesPkg`:
- `dna_base` is a 2-bit enum: A=0, C=1, G=2, T=3.
- `direction` is a 2-bit enum: NONE=0, DIAG=1, UP=2, LEFT=3.

Parameters:
- `len1`, default 10: length of `seq1`; the column count of the matrices.
- `len2`, default 9: length of `seq2`; the row count of the matrices.

Ports:
- `clk`, input, 1 bit: the single clock; all state changes on its rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset.
- `seq1`, input, `dna_base [0:len1-1]`: sequence indexed by i.
- `seq2`, input, `dna_base [0:len2-1]`: sequence indexed by j.
- `finished`, output, 1 bit: high when traceback is complete; held until reset.
- `maxRowId`, output, `$clog2(len1)+1` bits: the i index (seq1) of the maximum cell.
- `maxColId`, output, `$clog2(len2)+1` bits: the j index (seq2) of the maximum cell.
- `score_grid`, output, `[0:len1-1][15:0] [0:len2-1]`: `score_grid[j][i]`, unsigned 16-bit cell scores.
- `grid`, output, `direction [0:len2-1][0:len1-1]`: `grid[j][i]`, the direction chosen for each cell.
- `aligned_sequence`, output, `direction [0:len1+len2-1]`: traceback path, starting at the maximum cell.

## Operation
Scoring:
- Match scores +3, mismatch −3, gap −2.
- Cells outside the matrix (i=−1 or j=−1) read as score 0.

Cell rule for (j,i):
- Candidates are diag = S[j−1][i−1] ± 3, up = S[j−1][i] − 2, left = S[j][i−1] − 2.
- S = max(0, diag, up, left), computed in signed arithmetic of at least 18 bits, then stored as 16 bits.
- Direction is NONE when S = 0. Otherwise it is the first candidate equal to S in priority order DIAG > UP > LEFT.

Maximum tracking:
- The running maximum starts at 0.
- It is updated only when a new cell is strictly greater, so the first occurrence in row-major order (j outer, i inner) wins.
- If every cell scores 0, `maxRowId` and `maxColId` stay 0.

Traceback:
- Start at (maxColId, maxRowId) with k = 0.
- While the current cell score is > 0: write `aligned_sequence[k]` = `grid[j][i]`, increment k, and move. DIAG moves to (j−1,i−1), UP to (j−1,i), LEFT to (j,i−1).
- Stop when the next cell is off-grid or has score 0. Stop immediately if the starting score is 0.
- Unwritten entries of `aligned_sequence` remain NONE.

State machine:
- IDLE → FILL: one cycle after reset release. This edge latches `seq1` and `seq2` into internal registers; input changes after that are ignored until the next reset.
- FILL: one cell per cycle, row-major, from (0,0) to (len2−1,len1−1). After the last cell, go to TRACE.
- TRACE: one path step per cycle. Go to DONE when the stop condition is met.
- DONE: `finished`=1. The state and all outputs are frozen until reset.

## Timing
- Reset (`rst`=0): immediate and asynchronous.
  - `finished`=0, `maxRowId`=0, `maxColId`=0.
  - All `score_grid` entries = 0; all `grid` and `aligned_sequence` entries = NONE.
  - State = IDLE.
- `score_grid` and `grid` entries become valid on the edge that computes them. Entries not yet computed read 0/NONE.
- Latency from reset release to `finished`=1 is 1 + len1·len2 + (path length) + 1 cycles. The maximum is len1·len2 + len1 + len2 + 2.
- Reset asserted mid-run aborts the run: all outputs are cleared at once, and a fresh run starts after release.

## Test plan
- len1=len2=4, seq1=seq2=ACGT:
  - The diagonal scores 3, 6, 9, 12; max at (3,3), so `maxRowId`=3 and `maxColId`=3.
  - `aligned_sequence`[0..3]=DIAG; the rest are NONE.
- len1=len2=4, seq1=AAAA, seq2=CCCC:
  - All scores 0 and all `grid` entries NONE.
  - Max ids 0,0; `aligned_sequence` all NONE.
  - `finished` is asserted after 4·4 + 2 cycles.
- len1=3, len2=2, seq1=ACG, seq2=AG:
  - Row 0 scores 3,1,0 with directions DIAG, LEFT, NONE.
  - Row 1 scores 1,0,4 with directions UP, NONE, DIAG.
  - `maxRowId`=2, `maxColId`=1.
  - `aligned_sequence` = DIAG, LEFT, DIAG, NONE, NONE.
- len1=2, len2=1, seq1=AA, seq2=A (tie):
  - Scores 3,3.
  - `maxRowId`=0 and `maxColId`=0, because the first maximum wins.
  - `aligned_sequence` = DIAG, NONE, NONE.
- Default parameters, seq1=ATCAGTTGGA, seq2=GGCATTGTA:
  - `finished` is asserted within 90+21 cycles.
  - The score at (maxColId, maxRowId) equals the maximum of `score_grid`.
  - Every `aligned_sequence` step matches `grid` along the path.
- Drive `rst` low midway through FILL:
  - All outputs clear without waiting for a clock edge.
  - After release, the results are identical to an uninterrupted run.

Source files
------------

// File: rtl/short_solver.sv
// rtl/short_solver.sv - Smith-Waterman local aligner core with matrix fill and traceback
package datatypesPkg;
    typedef enum logic [1:0] {A = 2'd0, C = 2'd1, G = 2'd2, T = 2'd3} dna_base;
    typedef enum logic [1:0] {NONE = 2'd0, DIAG = 2'd1, UP = 2'd2, LEFT = 2'd3} direction;
endpackage

module short_solver
    import datatypesPkg::*;
#(
    parameter int len1 = 10,
    parameter int len2 = 9
) (
    input  logic                           clk,
    input  logic                           rst,
    input  dna_base [0:len1-1]             seq1,
    input  dna_base [0:len2-1]             seq2,
    output logic                           finished,
    output logic [$clog2(len1):0]          maxRowId,
    output logic [$clog2(len2):0]          maxColId,
    output logic [0:len1-1][15:0]          score_grid [0:len2-1],
    output direction [0:len2-1][0:len1-1]  grid,
    output direction [0:len1+len2-1]       aligned_sequence
);

    localparam int IW = (len1 > 1) ? $clog2(len1) : 1;
    localparam int JW = (len2 > 1) ? $clog2(len2) : 1;
    localparam int KW = $clog2(len1 + len2);
    localparam int RW = $clog2(len1) + 1;
    localparam int CW = $clog2(len2) + 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_TRACE, S_DONE} state_t;

    state_t                         state_q, state_d;
    dna_base [0:len1-1]             seq1_q, seq1_d;
    dna_base [0:len2-1]             seq2_q, seq2_d;
    logic [IW-1:0]                  ci_q, ci_d;
    logic [JW-1:0]                  cj_q, cj_d;
    logic [IW-1:0]                  ti_q, ti_d;
    logic [JW-1:0]                  tj_q, tj_d;
    logic                           off_q, off_d;
    logic [KW-1:0]                  k_q, k_d;
    logic [15:0]                    max_q, max_d;
    logic [IW-1:0]                  max_row_q, max_row_d;
    logic [JW-1:0]                  max_col_q, max_col_d;
    logic                           finished_q, finished_d;
    logic [0:len1-1][15:0]          score_q [0:len2-1];
    logic [0:len1-1][15:0]          score_d [0:len2-1];
    direction [0:len2-1][0:len1-1]  grid_q, grid_d;
    direction [0:len1+len2-1]       aligned_q, aligned_d;

    logic [15:0]        diag_src, up_src, left_src;
    logic               match;
    logic signed [17:0] diag_s, up_s, left_s, best;
    direction           cell_dir;
    logic [15:0]        cur_score;
    direction           cur_dir;

    // Score and direction of the cell currently being filled; off-grid neighbours read as 0
    always_comb begin
        diag_src = '0;
        up_src   = '0;
        left_src = '0;
        if (ci_q != '0 && cj_q != '0) diag_src = score_q[cj_q - 1'b1][ci_q - 1'b1];
        if (cj_q != '0)               up_src   = score_q[cj_q - 1'b1][ci_q];
        if (ci_q != '0)               left_src = score_q[cj_q][ci_q - 1'b1];
        match  = (seq1_q[ci_q] == seq2_q[cj_q]);
        diag_s = $signed({2'b00, diag_src}) + (match ? 18'sd3 : -18'sd3);
        up_s   = $signed({2'b00, up_src}) - 18'sd2;
        left_s = $signed({2'b00, left_src}) - 18'sd2;
        best   = '0;
        if (diag_s > best) best = diag_s;
        if (up_s > best)   best = up_s;
        if (left_s > best) best = left_s;
        if (best == 18'sd0)       cell_dir = NONE;
        else if (best == diag_s)  cell_dir = DIAG;
        else if (best == up_s)    cell_dir = UP;
        else                      cell_dir = LEFT;
    end

    // Cell under the traceback cursor
    always_comb begin
        cur_score = score_q[tj_q][ti_q];
        cur_dir   = grid_q[tj_q][ti_q];
    end

    // Next-state logic: latch inputs, fill cells row-major, then walk the path back
    always_comb begin
        state_d    = state_q;
        seq1_d     = seq1_q;
        seq2_d     = seq2_q;
        ci_d       = ci_q;
        cj_d       = cj_q;
        ti_d       = ti_q;
        tj_d       = tj_q;
        off_d      = off_q;
        k_d        = k_q;
        max_d      = max_q;
        max_row_d  = max_row_q;
        max_col_d  = max_col_q;
        finished_d = finished_q;
        score_d    = score_q;
        grid_d     = grid_q;
        aligned_d  = aligned_q;
        case (state_q)
            S_IDLE: begin
                seq1_d  = seq1;
                seq2_d  = seq2;
                ci_d    = '0;
                cj_d    = '0;
                state_d = S_FILL;
            end
            S_FILL: begin
                score_d[cj_q][ci_q] = best[15:0];
                grid_d[cj_q][ci_q]  = cell_dir;
                // Strictly greater keeps the first maximum in row-major order
                if (best[15:0] > max_q) begin
                    max_d     = best[15:0];
                    max_row_d = ci_q;
                    max_col_d = cj_q;
                end
                if (ci_q == IW'(len1 - 1)) begin
                    ci_d = '0;
                    if (cj_q == JW'(len2 - 1)) begin
                        state_d = S_TRACE;
                        ti_d    = max_row_d;
                        tj_d    = max_col_d;
                        off_d   = 1'b0;
                        k_d     = '0;
                    end else begin
                        cj_d = cj_q + 1'b1;
                    end
                end else begin
                    ci_d = ci_q + 1'b1;
                end
            end
            S_TRACE: begin
                if (off_q || cur_score == 16'd0) begin
                    state_d    = S_DONE;
                    finished_d = 1'b1;
                end else begin
                    aligned_d[k_q] = cur_dir;
                    k_d            = k_q + 1'b1;
                    // Stepping past row/column 0 marks the cursor off-grid
                    case (cur_dir)
                        DIAG: begin
                            if (ti_q == '0 || tj_q == '0) off_d = 1'b1;
                            else begin
                                ti_d = ti_q - 1'b1;
                                tj_d = tj_q - 1'b1;
                            end
                        end
                        UP: begin
                            if (tj_q == '0) off_d = 1'b1;
                            else tj_d = tj_q - 1'b1;
                        end
                        LEFT: begin
                            if (ti_q == '0) off_d = 1'b1;
                            else ti_d = ti_q - 1'b1;
                        end
                        default: off_d = 1'b1;
                    endcase
                end
            end
            default: begin
            end
        endcase
    end

    // State registers with asynchronous clear of all results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ci_q       <= '0;
            cj_q       <= '0;
            ti_q       <= '0;
            tj_q       <= '0;
            off_q      <= 1'b0;
            k_q        <= '0;
            max_q      <= '0;
            max_row_q  <= '0;
            max_col_q  <= '0;
            finished_q <= 1'b0;
            for (int i = 0; i < len1; i++) seq1_q[i] <= A;
            for (int j = 0; j < len2; j++) seq2_q[j] <= A;
            for (int j = 0; j < len2; j++) begin
                score_q[j] <= '0;
                for (int i = 0; i < len1; i++) grid_q[j][i] <= NONE;
            end
            for (int k = 0; k < len1 + len2; k++) aligned_q[k] <= NONE;
        end else begin
            state_q    <= state_d;
            seq1_q     <= seq1_d;
            seq2_q     <= seq2_d;
            ci_q       <= ci_d;
            cj_q       <= cj_d;
            ti_q       <= ti_d;
            tj_q       <= tj_d;
            off_q      <= off_d;
            k_q        <= k_d;
            max_q      <= max_d;
            max_row_q  <= max_row_d;
            max_col_q  <= max_col_d;
            finished_q <= finished_d;
            score_q    <= score_d;
            grid_q     <= grid_d;
            aligned_q  <= aligned_d;
        end
    end

    assign finished         = finished_q;
    assign maxRowId         = RW'(max_row_q);
    assign maxColId         = CW'(max_col_q);
    assign score_grid       = score_q;
    assign grid             = grid_q;
    assign aligned_sequence = aligned_q;

endmodule

// File: tb/tb_short_solver.sv
// tb/tb_short_solver.sv - self-checking bench for short_solver against a reference aligner
module tb_short_solver;
    import datatypesPkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4 = 1'b0, rst32 = 1'b0, rst21 = 1'b0, rst109 = 1'b0;

    dna_base [0:3] a4, b4;
    logic fin4; logic [2:0] row4, col4;
    logic [0:3][15:0] sg4 [0:3]; direction [0:3][0:3] g4; direction [0:7] al4;

    dna_base [0:2] a32; dna_base [0:1] b32;
    logic fin32; logic [2:0] row32; logic [1:0] col32;
    logic [0:2][15:0] sg32 [0:1]; direction [0:1][0:2] g32; direction [0:4] al32;

    dna_base [0:1] a21; dna_base [0:0] b21;
    logic fin21; logic [1:0] row21; logic [0:0] col21;
    logic [0:1][15:0] sg21 [0:0]; direction [0:0][0:1] g21; direction [0:2] al21;

    dna_base [0:9] a109; dna_base [0:8] b109;
    logic fin109; logic [4:0] row109, col109;
    logic [0:9][15:0] sg109 [0:8]; direction [0:8][0:9] g109; direction [0:18] al109;

    short_solver #(.len1(4), .len2(4)) u4 (.clk(clk), .rst(rst4), .seq1(a4), .seq2(b4),
        .finished(fin4), .maxRowId(row4), .maxColId(col4), .score_grid(sg4), .grid(g4),
        .aligned_sequence(al4));
    short_solver #(.len1(3), .len2(2)) u32 (.clk(clk), .rst(rst32), .seq1(a32), .seq2(b32),
        .finished(fin32), .maxRowId(row32), .maxColId(col32), .score_grid(sg32), .grid(g32),
        .aligned_sequence(al32));
    short_solver #(.len1(2), .len2(1)) u21 (.clk(clk), .rst(rst21), .seq1(a21), .seq2(b21),
        .finished(fin21), .maxRowId(row21), .maxColId(col21), .score_grid(sg21), .grid(g21),
        .aligned_sequence(al21));
    short_solver u109 (.clk(clk), .rst(rst109), .seq1(a109), .seq2(b109),
        .finished(fin109), .maxRowId(row109), .maxColId(col109), .score_grid(sg109), .grid(g109),
        .aligned_sequence(al109));

    int tests = 0, fails = 0;
    int L1, L2;
    int in1 [10];
    int in2 [9];
    int e_s [9][10];
    int e_d [9][10];
    int e_al [19];
    int e_row, e_col, e_plen, e_max;
    int c_s [9][10];
    int c_d [9][10];
    int c_al [19];
    int c_row, c_col, c_fin;

    // Reference aligner on a zero-padded integer matrix
    function automatic void model();
        int S [10][11];
        int dg, up, lf, v, i, j, k;
        for (int r = 0; r < 10; r++) for (int q = 0; q < 11; q++) S[r][q] = 0;
        for (int r = 0; r < 9; r++) for (int q = 0; q < 10; q++) begin e_s[r][q] = 0; e_d[r][q] = 0; end
        for (int q = 0; q < 19; q++) e_al[q] = 0;
        e_row = 0; e_col = 0; e_max = 0;
        for (int r = 0; r < L2; r++) begin
            for (int q = 0; q < L1; q++) begin
                dg = S[r][q] + ((in1[q] == in2[r]) ? 3 : -3);
                up = S[r][q+1] - 2;
                lf = S[r+1][q] - 2;
                v = 0;
                if (dg > v) v = dg;
                if (up > v) v = up;
                if (lf > v) v = lf;
                S[r+1][q+1] = v;
                e_s[r][q] = v;
                e_d[r][q] = (v == 0) ? 0 : (v == dg) ? 1 : (v == up) ? 2 : 3;
                if (v > e_max) begin e_max = v; e_row = q; e_col = r; end
            end
        end
        i = e_row; j = e_col; k = 0;
        while (k < L1 + L2 && i >= 0 && j >= 0) begin
            if (e_s[j][i] == 0) break;
            e_al[k] = e_d[j][i];
            k++;
            case (e_d[j][i])
                1: begin i--; j--; end
                2: j--;
                default: i--;
            endcase
        end
        e_plen = k;
    endfunction

    function automatic void drive(int id, bit garbage);
        int v1 [10];
        int v2 [9];
        for (int q = 0; q < 10; q++) v1[q] = garbage ? int'($urandom_range(0, 3)) : in1[q];
        for (int q = 0; q < 9; q++)  v2[q] = garbage ? int'($urandom_range(0, 3)) : in2[q];
        case (id)
            0: begin for (int q = 0; q < 4; q++) begin a4[q] = dna_base'(v1[q][1:0]); b4[q] = dna_base'(v2[q][1:0]); end end
            1: begin for (int q = 0; q < 3; q++) a32[q] = dna_base'(v1[q][1:0]);
                     for (int q = 0; q < 2; q++) b32[q] = dna_base'(v2[q][1:0]); end
            2: begin for (int q = 0; q < 2; q++) a21[q] = dna_base'(v1[q][1:0]);
                     b21[0] = dna_base'(v2[0][1:0]); end
            default: begin for (int q = 0; q < 10; q++) a109[q] = dna_base'(v1[q][1:0]);
                     for (int q = 0; q < 9; q++) b109[q] = dna_base'(v2[q][1:0]); end
        endcase
    endfunction

    function automatic void set_rst(int id, logic v);
        case (id)
            0: rst4 = v;
            1: rst32 = v;
            2: rst21 = v;
            default: rst109 = v;
        endcase
    endfunction

    function automatic logic fin_of(int id);
        case (id)
            0: return fin4;
            1: return fin32;
            2: return fin21;
            default: return fin109;
        endcase
    endfunction

    function automatic void cap(int id);
        for (int r = 0; r < 9; r++) for (int q = 0; q < 10; q++) begin c_s[r][q] = 0; c_d[r][q] = 0; end
        for (int q = 0; q < 19; q++) c_al[q] = 0;
        case (id)
            0: begin
                c_fin = int'(fin4); c_row = int'(row4); c_col = int'(col4);
                for (int r = 0; r < 4; r++) for (int q = 0; q < 4; q++) begin c_s[r][q] = int'(sg4[r][q]); c_d[r][q] = int'(g4[r][q]); end
                for (int q = 0; q < 8; q++) c_al[q] = int'(al4[q]);
            end
            1: begin
                c_fin = int'(fin32); c_row = int'(row32); c_col = int'(col32);
                for (int r = 0; r < 2; r++) for (int q = 0; q < 3; q++) begin c_s[r][q] = int'(sg32[r][q]); c_d[r][q] = int'(g32[r][q]); end
                for (int q = 0; q < 5; q++) c_al[q] = int'(al32[q]);
            end
            2: begin
                c_fin = int'(fin21); c_row = int'(row21); c_col = int'(col21);
                for (int q = 0; q < 2; q++) begin c_s[0][q] = int'(sg21[0][q]); c_d[0][q] = int'(g21[0][q]); end
                for (int q = 0; q < 3; q++) c_al[q] = int'(al21[q]);
            end
            default: begin
                c_fin = int'(fin109); c_row = int'(row109); c_col = int'(col109);
                for (int r = 0; r < 9; r++) for (int q = 0; q < 10; q++) begin c_s[r][q] = int'(sg109[r][q]); c_d[r][q] = int'(g109[r][q]); end
                for (int q = 0; q < 19; q++) c_al[q] = int'(al109[q]);
            end
        endcase
    endfunction

    function automatic int grid_diffs();
        int n = 0;
        for (int r = 0; r < L2; r++) for (int q = 0; q < L1; q++)
            if (c_s[r][q] != e_s[r][q] || c_d[r][q] != e_d[r][q]) n++;
        return n;
    endfunction

    function automatic int path_diffs();
        int n = 0;
        for (int q = 0; q < L1 + L2; q++) if (c_al[q] != e_al[q]) n++;
        return n;
    endfunction

    function automatic int nonzero_count();
        int n = 0;
        for (int r = 0; r < 9; r++) for (int q = 0; q < 10; q++) if (c_s[r][q] != 0 || c_d[r][q] != 0) n++;
        for (int q = 0; q < 19; q++) if (c_al[q] != 0) n++;
        return n;
    endfunction

    task automatic run(input int id, input bit scramble, output int cyc);
        @(negedge clk);
        set_rst(id, 1'b0);
        drive(id, 1'b0);
        @(negedge clk);
        set_rst(id, 1'b1);
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (scramble && cyc == 2) drive(id, 1'b1);
            if (fin_of(id)) break;
        end
        cap(id);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst109 = 1'b0;
        @(posedge clk); #1;
        cap(3);
        tests++;
        if (c_fin !== 0 || c_row !== 0 || c_col !== 0)
            begin fails++; $display("FAIL reset_ids: fin=%0d row=%0d col=%0d required 0 0 0", c_fin, c_row, c_col); end
        tests++;
        if (nonzero_count() !== 0)
            begin fails++; $display("FAIL reset_arrays: %0d nonzero entries, required 0", nonzero_count()); end
    endtask

    task automatic test_identity();
        int cyc, bad;
        L1 = 4; L2 = 4;
        for (int q = 0; q < 4; q++) begin in1[q] = q; in2[q] = q; end
        model();
        run(0, 1'b0, cyc);
        tests++;
        if (c_row !== 3 || c_col !== 3)
            begin fails++; $display("FAIL ident_max: row=%0d col=%0d required 3 3", c_row, c_col); end
        bad = 0;
        for (int q = 0; q < 4; q++) if (c_s[q][q] != 3 * (q + 1)) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL ident_diag: %0d diagonal scores wrong, required 3,6,9,12", bad); end
        bad = 0;
        for (int q = 0; q < 8; q++) if (c_al[q] != ((q < 4) ? 1 : 0)) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL ident_path: %0d path entries wrong, required 4xDIAG then NONE", bad); end
        tests++;
        if (cyc !== 22) begin fails++; $display("FAIL ident_latency: %0d cycles, required 22", cyc); end
        tests++;
        if (grid_diffs() !== 0) begin fails++; $display("FAIL ident_grid: %0d cells differ from model", grid_diffs()); end
    endtask

    task automatic test_no_match();
        int cyc;
        L1 = 4; L2 = 4;
        for (int q = 0; q < 4; q++) begin in1[q] = 0; in2[q] = 1; end
        run(0, 1'b0, cyc);
        tests++;
        if (nonzero_count() !== 0) begin fails++; $display("FAIL nomatch_arrays: %0d nonzero entries, required 0", nonzero_count()); end
        tests++;
        if (c_row !== 0 || c_col !== 0 || c_fin !== 1)
            begin fails++; $display("FAIL nomatch_ids: row=%0d col=%0d fin=%0d required 0 0 1", c_row, c_col, c_fin); end
        tests++;
        if (cyc !== 18) begin fails++; $display("FAIL nomatch_latency: %0d cycles, required 18", cyc); end
    endtask

    task automatic test_small();
        int cyc, bad;
        int xs [6] = '{3, 1, 0, 1, 0, 4};
        int xd [6] = '{1, 3, 0, 2, 0, 1};
        int xa [5] = '{1, 3, 1, 0, 0};
        L1 = 3; L2 = 2;
        in1[0] = 0; in1[1] = 1; in1[2] = 2; in2[0] = 0; in2[1] = 2;
        run(1, 1'b0, cyc);
        bad = 0;
        for (int r = 0; r < 2; r++) for (int q = 0; q < 3; q++)
            if (c_s[r][q] != xs[r*3+q] || c_d[r][q] != xd[r*3+q]) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL small_grid: %0d cells wrong", bad); end
        tests++;
        if (c_row !== 2 || c_col !== 1) begin fails++; $display("FAIL small_max: row=%0d col=%0d required 2 1", c_row, c_col); end
        bad = 0;
        for (int q = 0; q < 5; q++) if (c_al[q] != xa[q]) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL small_path: %0d entries wrong", bad); end
        tests++;
        if (cyc !== 1 + 6 + 3 + 1) begin fails++; $display("FAIL small_latency: %0d cycles, required 11", cyc); end
    endtask

    task automatic test_tie();
        int cyc;
        L1 = 2; L2 = 1;
        in1[0] = 0; in1[1] = 0; in2[0] = 0;
        run(2, 1'b0, cyc);
        tests++;
        if (c_s[0][0] !== 3 || c_s[0][1] !== 3)
            begin fails++; $display("FAIL tie_scores: %0d %0d required 3 3", c_s[0][0], c_s[0][1]); end
        tests++;
        if (c_row !== 0 || c_col !== 0) begin fails++; $display("FAIL tie_max: row=%0d col=%0d required 0 0", c_row, c_col); end
        tests++;
        if (c_al[0] !== 1 || c_al[1] !== 0 || c_al[2] !== 0)
            begin fails++; $display("FAIL tie_path: %0d %0d %0d required 1 0 0", c_al[0], c_al[1], c_al[2]); end
    endtask

    task automatic test_default_seq();
        int cyc, mx, i, j, bad;
        int s1 [10] = '{0, 3, 1, 0, 2, 3, 3, 2, 2, 0};
        int s2 [9]  = '{2, 2, 1, 0, 3, 3, 2, 3, 0};
        L1 = 10; L2 = 9;
        in1 = s1; in2 = s2;
        model();
        run(3, 1'b0, cyc);
        tests++;
        if (cyc > 111 || cyc !== 92 + e_plen)
            begin fails++; $display("FAIL dflt_latency: %0d cycles, required %0d", cyc, 92 + e_plen); end
        mx = 0;
        for (int r = 0; r < 9; r++) for (int q = 0; q < 10; q++) if (c_s[r][q] > mx) mx = c_s[r][q];
        tests++;
        if (c_s[c_col][c_row] !== mx)
            begin fails++; $display("FAIL dflt_maxcell: %0d at max ids, grid max %0d", c_s[c_col][c_row], mx); end
        bad = 0; i = c_row; j = c_col;
        for (int q = 0; q < 19 && c_al[q] != 0; q++) begin
            if (i < 0 || j < 0 || c_al[q] != c_d[j][i]) begin bad++; break; end
            if (c_al[q] == 1) begin i--; j--; end else if (c_al[q] == 2) j--; else i--;
        end
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL dflt_walk: path disagrees with grid (%0d)", bad); end
        tests++;
        if (grid_diffs() + path_diffs() !== 0 || c_row !== e_row || c_col !== e_col)
            begin fails++; $display("FAIL dflt_model: grid=%0d path=%0d ids %0d,%0d required %0d,%0d",
                grid_diffs(), path_diffs(), c_row, c_col, e_row, e_col); end
    endtask

    task automatic test_random();
        int cyc, id;
        for (int n = 0; n < 12; n++) begin
            id = (n % 2 == 0) ? 3 : 0;
            L1 = (id == 3) ? 10 : 4; L2 = (id == 3) ? 9 : 4;
            for (int q = 0; q < 10; q++) in1[q] = $urandom_range(0, 3);
            for (int q = 0; q < 9; q++) in2[q] = (n < 6 && q < L1) ? in1[q] : int'($urandom_range(0, 3));
            model();
            run(id, 1'b1, cyc);
            tests++;
            if (grid_diffs() !== 0 || path_diffs() !== 0)
                begin fails++; $display("FAIL rand%0d_arrays: grid=%0d path=%0d differences", n, grid_diffs(), path_diffs()); end
            tests++;
            if (c_row !== e_row || c_col !== e_col || cyc !== 2 + L1 * L2 + e_plen)
                begin fails++; $display("FAIL rand%0d_ids: row=%0d col=%0d cyc=%0d required %0d %0d %0d",
                    n, c_row, c_col, cyc, e_row, e_col, 2 + L1 * L2 + e_plen); end
        end
    endtask

    task automatic test_midreset();
        int cyc;
        L1 = 10; L2 = 9;
        for (int q = 0; q < 10; q++) in1[q] = $urandom_range(0, 3);
        for (int q = 0; q < 9; q++) in2[q] = $urandom_range(0, 3);
        model();
        @(negedge clk); rst109 = 1'b0; drive(3, 1'b0);
        @(negedge clk); rst109 = 1'b1;
        repeat (40) @(posedge clk);
        #3 rst109 = 1'b0;
        #1 cap(3);
        tests++;
        if (nonzero_count() !== 0 || c_fin !== 0 || c_row !== 0 || c_col !== 0)
            begin fails++; $display("FAIL midrst_clear: %0d nonzero entries, ids %0d,%0d", nonzero_count(), c_row, c_col); end
        @(negedge clk); rst109 = 1'b1;
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (fin109) break;
        end
        cap(3);
        tests++;
        if (grid_diffs() !== 0 || path_diffs() !== 0 || c_row !== e_row || c_col !== e_col || cyc !== 92 + e_plen)
            begin fails++; $display("FAIL midrst_rerun: grid=%0d path=%0d ids %0d,%0d cyc=%0d required %0d,%0d %0d",
                grid_diffs(), path_diffs(), c_row, c_col, cyc, e_row, e_col, 92 + e_plen); end
    endtask

    initial begin
        for (int q = 0; q < 10; q++) begin in1[q] = 0; if (q < 9) in2[q] = 0; end
        drive(0, 1'b0); drive(1, 1'b0); drive(2, 1'b0); drive(3, 1'b0);
        test_reset();
        test_identity();
        test_no_match();
        test_small();
        test_tie();
        test_default_seq();
        test_random();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
